// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// The slave modport is the datapath's view; the master modport is the source/sink side.
interface pipelined_addsub_if #(
  parameter int unsigned N = 32
);
  logic         i_Valid;
  logic         o_Ready;
  logic [N-1:0] i_X;
  logic [N-1:0] i_Y;
  logic         i_Sub;
  logic         i_Cin;
  logic         o_Valid;
  logic         i_Ready;
  logic [N-1:0] o_D;
  logic         o_N;
  logic         o_Z;
  logic         o_C;
  logic         o_V;

  modport slave (
    input  i_Valid, i_X, i_Y, i_Sub, i_Cin, i_Ready,
    output o_Ready, o_Valid, o_D, o_N, o_Z, o_C, o_V
  );

  modport master (
    output i_Valid, i_X, i_Y, i_Sub, i_Cin, i_Ready,
    input  o_Ready, o_Valid, o_D, o_N, o_Z, o_C, o_V
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined N-bit add/subtract with ARM NZCV flags. One S-bit slice is resolved per stage,
// with the slice carry registered between stages, so the critical path is an S-bit adder.
module pipelined_addsub #(
  parameter int unsigned N = 32,
  parameter int unsigned S = 8
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  pipelined_addsub_if.slave   bus
);
  localparam int unsigned L = N / S;

  // Per-stage registers; stage k holds result bits [(k+1)*S-1:0] fully resolved.
  logic [L-1:0] valid_q;
  logic [L-1:0] sub_q;
  logic [L-1:0] carry_q;
  logic [N-1:0] x_q [L];
  logic [N-1:0] y_q [L];
  logic [N-1:0] d_q [L];

  // What each stage sees on its input side: the previous stage, or the bus for stage 0.
  logic [L-1:0] in_valid;
  logic [L-1:0] in_sub;
  logic [L-1:0] in_cin;
  logic [N-1:0] in_x [L];
  logic [N-1:0] in_y [L];
  logic [N-1:0] in_d [L];
  logic [N-1:0] nxt_d [L];
  logic [L-1:0] nxt_c;

  logic advance;

  // A full final stage that the sink refuses freezes the whole pipe.
  assign advance = !valid_q[L-1] || bus.i_Ready;

  // Route stage inputs and resolve one slice per stage.
  always_comb begin
    logic [S:0] sum;
    sum      = '0;
    in_valid = '0;
    in_sub   = '0;
    in_cin   = '0;
    nxt_c    = '0;
    in_x     = '{default: '0};
    in_y     = '{default: '0};
    in_d     = '{default: '0};
    nxt_d    = '{default: '0};

    in_valid[0] = bus.i_Valid;
    in_sub[0]   = bus.i_Sub;
    in_cin[0]   = bus.i_Cin;
    in_x[0]     = bus.i_X;
    in_y[0]     = bus.i_Y;
    for (int k = 1; k < L; k++) begin
      in_valid[k] = valid_q[k-1];
      in_sub[k]   = sub_q[k-1];
      in_cin[k]   = carry_q[k-1];
      in_x[k]     = x_q[k-1];
      in_y[k]     = y_q[k-1];
      in_d[k]     = d_q[k-1];
    end

    // Y travels raw; each stage inverts only its own slice when subtracting.
    for (int k = 0; k < L; k++) begin
      sum = {1'b0, in_x[k][k*S +: S]}
          + {1'b0, in_y[k][k*S +: S] ^ {S{in_sub[k]}}}
          + {{S{1'b0}}, in_cin[k]};
      nxt_d[k]            = in_d[k];
      nxt_d[k][k*S +: S]  = sum[S-1:0];
      nxt_c[k]            = sum[S];
    end
  end

  // Shift every stage on advance; payload only loads behind a valid op to save toggling.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      valid_q <= '0;
      sub_q   <= '0;
      carry_q <= '0;
      for (int k = 0; k < L; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        d_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < L; k++) begin
        valid_q[k] <= in_valid[k];
        if (in_valid[k]) begin
          sub_q[k]   <= in_sub[k];
          carry_q[k] <= nxt_c[k];
          x_q[k]     <= in_x[k];
          y_q[k]     <= in_y[k];
          d_q[k]     <= nxt_d[k];
        end
      end
    end
  end

  assign bus.o_Ready = advance;
  assign bus.o_Valid = valid_q[L-1];
  assign bus.o_D     = d_q[L-1];
  assign bus.o_N     = d_q[L-1][N-1];
  // Zero flag is qualified so an idle or resetting pipe never reports Z.
  assign bus.o_Z     = !i_Reset && valid_q[L-1] && (d_q[L-1] == '0);
  assign bus.o_C     = carry_q[L-1];
  // Operands with equal sign (after Y inversion) producing a result of the other sign.
  assign bus.o_V     = ((x_q[L-1][N-1] == (y_q[L-1][N-1] ^ sub_q[L-1])) &&
                        (d_q[L-1][N-1] != x_q[L-1][N-1]));
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined N-bit adder/subtractor for the ARM datapath, producing a result plus ARM-convention NZCV flags. The operand is split into S-bit slices, one slice resolved per pipeline stage with the carry registered between stages. This gives one operation per cycle at a clock rate independent of N. It sits between the operand-fetch stage and the flag/writeback logic and accepts ADD, ADC, SUB and SBC with a valid/ready handshake.

## Interface
- N, 32, operand/result width in bits; must be a multiple of S
- S, 8, slice width per pipeline stage; pipeline depth L = N/S (S = N gives L = 1)
- i_Clk  input  1  clock, all state updates on rising edge
- i_Reset  input  1  synchronous reset, active-high
- i_Valid  input  1  operation presented on i_X/i_Y/i_Sub/i_Cin
- o_Ready  output  1  block accepts an operation this cycle
- i_X  input  N  minuend / first addend
- i_Y  input  N  subtrahend / second addend
- i_Sub  input  1  1 = X − Y, 0 = X + Y
- i_Cin  input  1  ARM carry in: add uses X+Y+Cin; sub uses X−Y−(1−Cin), so Cin=1 means no borrow
- o_Valid  output  1  result/flags valid
- i_Ready  input  1  downstream accepts result
- o_D  output  N  result modulo 2^N
- o_N  output  1  o_D[N-1]
- o_Z  output  1  o_D == 0
- o_C  output  1  add: carry out; sub: NOT borrow (1 when X ≥ Y + (1−Cin), unsigned)
- o_V  output  1  signed overflow

## Operation
- Sub is implemented as X + ~Y + Cin. Stage k (0..L−1) adds slice k of X and the conditionally inverted Y, plus the registered carry from stage k−1; stage 0 uses i_Cin.
- Higher slices of the operands travel down the pipeline unprocessed. Finished low slices are delayed so all N result bits exit stage L−1 together.
- Each stage carries a valid bit plus i_Sub. Only the final stage's registers drive outputs.
- Flags are computed from the final-stage registers:
  - o_V = (X[N−1] == Y'[N−1]) && (D[N−1] != X[N−1]), where Y' is the inverted Y for sub.
  - o_Z is a full N-bit zero-detect of the registered result.
- Handshake: advance = !o_Valid || i_Ready; o_Ready = advance.
  - On advance, every stage shifts by one. The operation is captured when i_Valid && o_Ready; otherwise a bubble (valid=0) enters.
  - When !advance, all stages hold. o_D, flags and o_Valid stay stable until accepted.
- An input is accepted only when i_Valid && o_Ready. The source must hold i_X/i_Y/i_Sub/i_Cin stable while i_Valid && !o_Ready.

## Timing
- Reset: all stage valid bits = 0; o_Valid = 0, o_Ready = 1, o_D = 0, o_N = o_Z = o_C = o_V = 0 (o_Z is forced 0, not derived, while in reset).
- Reset wins over a simultaneous i_Valid. Reset mid-operation discards every in-flight operation; nothing is output for them.
- Latency: an operation accepted at edge t appears with o_Valid = 1 after edge t+L−1, i.e. L cycles of register delay, given no stall.
- Throughput: one op per cycle while i_Ready = 1. Bubbles propagate but do not stall the pipeline.
- Stall: with a full pipeline and i_Ready = 0, no input is accepted and no stage moves. When i_Ready returns to 1, output resumes on the next edge with no loss or duplication.
- Wrap-around: o_D is modulo 2^N. Carry out of bit N−1 goes only to o_C.

## Test plan
- Reset then idle, N=32, S=8: after reset o_Valid=0, o_Ready=1, all outputs 0. Assert i_Reset in the same cycle as i_Valid: nothing emerges.
- SUB 5−3, Cin=1 → o_D=0x00000002, NZCV=0010 after 4 cycles. SUB 3−5, Cin=1 → 0xFFFFFFFE, NZCV=1000. SBC 5−3, Cin=0 → 0x00000001, C=1.
- Overflow cases:
  - SUB 0x80000000−1, Cin=1 → 0x7FFFFFFF, NZCV=0011.
  - ADD 0x7FFFFFFF+1, Cin=0 → 0x80000000, NZCV=1001.
  - ADD 0xFFFFFFFF+1, Cin=0 → 0x00000000, NZCV=0110.
- Cross-slice carry: ADD 0x00FFFFFF+0x00000001 → 0x01000000. SUB 0x01000000−1 → 0x00FFFFFF, C=1. This proves the carry/borrow ripple across every stage boundary.
- Streaming with backpressure: issue 10 back-to-back ops with i_Ready=1, then hold i_Ready=0 for 3 cycles mid-stream. Results must arrive in order, stable during the stall, with no loss or duplication, and o_Ready=0 throughout the stall.
- Parameter sweep (N=32,S=32 → latency 1; N=16,S=4 → latency 4): results match a reference model of X±Y and NZCV over 10k random ops, including random i_Ready. Separately, reset mid-stream flushes all in-flight ops.
